// File: rtl/mask_unit_read_scheduler.sv
// rtl/mask_unit_read_scheduler.sv - splits a bulk mask-unit read into rotated per-slot crossbar reads
module mask_unit_read_scheduler #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_vs,
    input  logic [8:0]  cmd_offset,
    input  logic [6:0]  cmd_count,
    input  logic [1:0]  cmd_laneRot,
    output logic [3:0]  read_valid,
    input  logic [3:0]  read_ready,
    output logic [19:0] read_vs,
    output logic [35:0] read_offset,
    output logic [7:0]  read_readLane,
    output logic [7:0]  read_dataOffset,
    input  logic [3:0]  resp_valid,
    output logic        busy,
    output logic        done,
    output logic        err_unexpected_resp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // A round may open only if a full round of four accepts still fits under the credit cap.
    localparam logic [3:0] OPEN_LIMIT = 4'(MAX_OUTSTANDING - 4);

    state_t      state_q;
    logic [4:0]  vs_q;
    logic [8:0]  offset_q;
    logic [6:0]  count_q;
    logic [1:0]  rot_q;
    logic [4:0]  round_q;
    logic [3:0]  pending_q;
    logic        open_q;
    logic [3:0]  out_q;
    logic        done_q;
    logic        err_q;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [3:0] round_mask(input logic [4:0] r, input logic [6:0] c);
        logic [3:0] m;
        m = '0;
        for (int s = 0; s < 4; s++) begin
            m[s] = ({1'b0, r, 2'b00} + 8'(s)) < {1'b0, c};
        end
        return m;
    endfunction

    logic [3:0] accept;
    logic [3:0] pending_left;
    logic [4:0] round_inc;
    logic       last_round;
    logic [2:0] resp_cnt;
    logic [4:0] credit_sum;
    logic       resp_over;
    logic [4:0] out_d;

    assign read_valid   = (state_q == S_ISSUE) ? (pending_q & {4{open_q}}) : 4'b0000;
    assign accept       = read_valid & read_ready;
    assign pending_left = pending_q & ~accept;
    assign round_inc    = round_q + 5'd1;
    assign last_round   = {1'b0, round_inc, 2'b00} >= {1'b0, count_q};

    assign resp_cnt   = popcount4(resp_valid);
    assign credit_sum = {1'b0, out_q} + {2'b00, popcount4(accept)};
    assign resp_over  = {2'b00, resp_cnt} > credit_sum;
    // Surplus responses (stale or spurious) flag an error and floor the count at zero.
    assign out_d      = resp_over ? 5'd0 : (credit_sum - {2'b00, resp_cnt});

    assign cmd_ready           = (state_q == S_IDLE);
    assign busy                = (state_q != S_IDLE);
    assign done                = done_q;
    assign err_unexpected_resp = err_q;

    // Slot fields are zeroed when the slot is idle; they are stable while valid waits.
    always_comb begin
        read_vs         = '0;
        read_offset     = '0;
        read_readLane   = '0;
        read_dataOffset = '0;
        for (int s = 0; s < 4; s++) begin
            if (read_valid[s]) begin
                read_vs[5*s +: 5]         = vs_q;
                read_offset[9*s +: 9]     = offset_q + {4'b0000, round_q};
                read_readLane[2*s +: 2]   = 2'(s) + round_q[1:0] + rot_q;
                read_dataOffset[2*s +: 2] = round_q[1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            vs_q      <= '0;
            offset_q  <= '0;
            count_q   <= '0;
            rot_q     <= '0;
            round_q   <= '0;
            pending_q <= '0;
            open_q    <= 1'b0;
            out_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            out_q  <= out_d[3:0];
            done_q <= 1'b0;
            if (resp_over) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        vs_q     <= cmd_vs;
                        offset_q <= cmd_offset;
                        count_q  <= cmd_count;
                        rot_q    <= cmd_laneRot;
                        round_q  <= '0;
                        if (cmd_count == 7'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            pending_q <= round_mask(5'd0, cmd_count);
                            open_q    <= (out_q <= OPEN_LIMIT);
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!open_q) begin
                        if (out_q <= OPEN_LIMIT) begin
                            open_q <= 1'b1;
                        end
                    end else if (pending_left == 4'b0000) begin
                        open_q  <= 1'b0;
                        round_q <= round_inc;
                        if (last_round) begin
                            pending_q <= '0;
                            state_q   <= S_DRAIN;
                        end else begin
                            pending_q <= round_mask(round_inc, count_q);
                        end
                    end else begin
                        pending_q <= pending_left;
                    end
                end
                S_DRAIN: begin
                    if (out_q == 4'd0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_unit_read_scheduler.sv
// tb/tb_mask_unit_read_scheduler.sv - directed bench for mask_unit_read_scheduler
module tb_mask_unit_read_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_vs;
    logic [8:0]  cmd_offset;
    logic [6:0]  cmd_count;
    logic [1:0]  cmd_laneRot;
    logic [3:0]  read_valid;
    logic [3:0]  read_ready;
    logic [19:0] read_vs;
    logic [35:0] read_offset;
    logic [7:0]  read_readLane;
    logic [7:0]  read_dataOffset;
    logic [3:0]  resp_valid;
    logic        busy;
    logic        done;
    logic        err_unexpected_resp;

    int passed = 0;
    int total  = 0;

    mask_unit_read_scheduler #(.MAX_OUTSTANDING(8)) dut (
        .clock               (clock),
        .reset               (reset),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_vs              (cmd_vs),
        .cmd_offset          (cmd_offset),
        .cmd_count           (cmd_count),
        .cmd_laneRot         (cmd_laneRot),
        .read_valid          (read_valid),
        .read_ready          (read_ready),
        .read_vs             (read_vs),
        .read_offset         (read_offset),
        .read_readLane       (read_readLane),
        .read_dataOffset     (read_dataOffset),
        .resp_valid          (resp_valid),
        .busy                (busy),
        .done                (done),
        .err_unexpected_resp (err_unexpected_resp)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic issue_cmd(input logic [4:0] vs, input logic [8:0] off,
                             input logic [6:0] cnt, input logic [1:0] rot);
        chk("cmd_ready_before_issue", 64'(cmd_ready), 64'd1);
        cmd_valid   = 1'b1;
        cmd_vs      = vs;
        cmd_offset  = off;
        cmd_count   = cnt;
        cmd_laneRot = rot;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_vs = '0; cmd_offset = '0;
        cmd_count = '0; cmd_laneRot = '0; read_ready = '0; resp_valid = '0;
        tick();
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_unexpected_resp), 64'd0);
        chk("rst_valid", 64'(read_valid), 64'd0);
        chk("rst_lane", 64'(read_readLane), 64'd0);
        chk("rst_offset", 64'(read_offset), 64'd0);
        reset = 1'b0;

        // count=4, no rotation, full ready, responses one cycle later
        read_ready = 4'b1111;
        issue_cmd(5'h0A, 9'h010, 7'd4, 2'd0);
        chk("t1_valid", 64'(read_valid), 64'hF);
        chk("t1_lane", 64'(read_readLane), 64'hE4);
        chk("t1_offset", 64'(read_offset), 64'({9'h010, 9'h010, 9'h010, 9'h010}));
        chk("t1_vs", 64'(read_vs), 64'({5'h0A, 5'h0A, 5'h0A, 5'h0A}));
        chk("t1_doff", 64'(read_dataOffset), 64'h00);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        chk("t1_c2_valid", 64'(read_valid), 64'h0);
        resp_valid = 4'b1111;
        tick();
        resp_valid = 4'b0000;
        chk("t1_c3_done", 64'(done), 64'd0);
        tick();
        chk("t1_c4_done", 64'(done), 64'd1);
        chk("t1_c4_cmd_ready", 64'(cmd_ready), 64'd0);
        tick();
        chk("t1_c5_done", 64'(done), 64'd0);
        chk("t1_c5_idle", 64'(cmd_ready), 64'd1);
        chk("t1_err", 64'(err_unexpected_resp), 64'd0);

        // count=6, rotation 1, offset wraps from 0x1FF
        issue_cmd(5'h13, 9'h1FF, 7'd6, 2'd1);
        chk("t2_r0_valid", 64'(read_valid), 64'hF);
        chk("t2_r0_lane", 64'(read_readLane), 64'h39);
        chk("t2_r0_offset", 64'(read_offset), 64'({9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}));
        tick();
        chk("t2_gap_valid", 64'(read_valid), 64'h0);
        tick();
        chk("t2_r1_valid", 64'(read_valid), 64'h3);
        chk("t2_r1_lane", 64'(read_readLane), 64'h0E);
        chk("t2_r1_offset", 64'(read_offset), 64'd0);
        chk("t2_r1_doff", 64'(read_dataOffset), 64'h05);
        chk("t2_r1_vs", 64'(read_vs), 64'({5'h00, 5'h00, 5'h13, 5'h13}));
        resp_valid = 4'b1111;
        tick();
        resp_valid = 4'b0001;
        chk("t2_c4_done", 64'(done), 64'd0);
        tick();
        resp_valid = 4'b0010;
        chk("t2_c5_done", 64'(done), 64'd0);
        tick();
        resp_valid = 4'b0000;
        chk("t2_c6_done", 64'(done), 64'd0);
        tick();
        chk("t2_c7_done", 64'(done), 64'd1);
        chk("t2_err", 64'(err_unexpected_resp), 64'd0);
        tick();

        // conflict retry: slots 1 and 3 denied for three cycles
        read_ready = 4'b0101;
        issue_cmd(5'h01, 9'h055, 7'd4, 2'd2);
        chk("t3_c1_valid", 64'(read_valid), 64'hF);
        chk("t3_c1_lane", 64'(read_readLane), 64'h4E);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("t3_hold_valid", 64'(read_valid), 64'hA);
            chk("t3_hold_lane", 64'(read_readLane), 64'h4C);
            chk("t3_hold_offset", 64'(read_offset), 64'({9'h055, 9'h000, 9'h055, 9'h000}));
        end
        read_ready = 4'b1111;
        tick();
        chk("t3_no_round1", 64'(read_valid), 64'h0);
        resp_valid = 4'b1111;
        tick();
        resp_valid = 4'b0000;
        tick();
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_err", 64'(err_unexpected_resp), 64'd0);
        tick();

        // credit limit: 16 elements, no responses until the cap blocks round 2
        issue_cmd(5'h02, 9'h100, 7'd16, 2'd0);
        chk("t4_c1_valid", 64'(read_valid), 64'hF);
        tick();
        chk("t4_c2_valid", 64'(read_valid), 64'h0);
        tick();
        chk("t4_c3_valid", 64'(read_valid), 64'hF);
        chk("t4_c3_doff", 64'(read_dataOffset), 64'h55);
        chk("t4_c3_offset", 64'(read_offset), 64'({9'h101, 9'h101, 9'h101, 9'h101}));
        chk("t4_c3_lane", 64'(read_readLane), 64'h39);
        tick();
        chk("t4_c4_valid", 64'(read_valid), 64'h0);
        tick();
        chk("t4_c5_blocked", 64'(read_valid), 64'h0);
        resp_valid = 4'b1111;
        tick();
        resp_valid = 4'b0000;
        chk("t4_c6_valid", 64'(read_valid), 64'h0);
        tick();
        chk("t4_r2_valid", 64'(read_valid), 64'hF);
        chk("t4_r2_doff", 64'(read_dataOffset), 64'hAA);
        chk("t4_r2_offset", 64'(read_offset), 64'({9'h102, 9'h102, 9'h102, 9'h102}));
        chk("t4_r2_lane", 64'(read_readLane), 64'h4E);
        tick();
        resp_valid = 4'b1111;
        tick();
        resp_valid = 4'b0000;
        chk("t4_c9_valid", 64'(read_valid), 64'h0);
        tick();
        chk("t4_r3_valid", 64'(read_valid), 64'hF);
        chk("t4_r3_doff", 64'(read_dataOffset), 64'hFF);
        tick();
        resp_valid = 4'b1111;
        tick();
        tick();
        resp_valid = 4'b0000;
        chk("t4_c13_done", 64'(done), 64'd0);
        tick();
        chk("t4_c14_done", 64'(done), 64'd1);
        chk("t4_err", 64'(err_unexpected_resp), 64'd0);
        tick();

        // count=0 completes at once; a response while idle is unexpected
        issue_cmd(5'h05, 9'h000, 7'd0, 2'd0);
        chk("t5_done", 64'(done), 64'd1);
        chk("t5_valid", 64'(read_valid), 64'h0);
        tick();
        chk("t5_done_clear", 64'(done), 64'd0);
        chk("t5_idle", 64'(cmd_ready), 64'd1);
        resp_valid = 4'b0001;
        tick();
        resp_valid = 4'b0000;
        chk("t5_err_set", 64'(err_unexpected_resp), 64'd1);
        tick();
        tick();
        chk("t5_err_sticky", 64'(err_unexpected_resp), 64'd1);

        // reset in the middle of ISSUE with three reads outstanding
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_err_cleared", 64'(err_unexpected_resp), 64'd0);
        read_ready = 4'b0111;
        issue_cmd(5'h07, 9'h0AA, 7'd8, 2'd0);
        chk("t6_c1_valid", 64'(read_valid), 64'hF);
        tick();
        chk("t6_c2_valid", 64'(read_valid), 64'h8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        read_ready = 4'b0000;
        chk("t6_idle", 64'(cmd_ready), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_valid", 64'(read_valid), 64'h0);
        chk("t6_lane", 64'(read_readLane), 64'h0);
        resp_valid = 4'b0001;
        tick();
        resp_valid = 4'b0000;
        chk("t6_stale_err", 64'(err_unexpected_resp), 64'd1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mask_unit_read_scheduler.md
Name: mask_unit_read_scheduler

Overview:
- Sequences a bulk mask-unit register read into per-requester element reads.
- Drives the four requester input slots of the mask-unit read crossbar and rotates lane assignment to reduce slot-to-lane conflicts.
- Holds and retries requests the crossbar denies, and bounds in-flight reads with a credit counter.
- Sits between the mask-unit control FSM (command/done) and the read crossbar/lane response path.

Parameters:
- MAX_OUTSTANDING, 8: maximum accepted-but-unanswered reads. Legal range 4..15.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  bulk read command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_vs  in  5  source vector register.
- cmd_offset  in  9  base offset.
- cmd_count  in  7  elements to read, 0..64.
- cmd_laneRot  in  2  lane rotation seed.
- read_valid  out  4  per-slot request valid; bit s = slot s.
- read_ready  in  4  per-slot crossbar ready.
- read_vs  out  20  slot s at [5s+4:5s].
- read_offset  out  36  slot s at [9s+8:9s].
- read_readLane  out  8  slot s at [2s+1:2s].
- read_dataOffset  out  8  slot s at [2s+1:2s].
- resp_valid  in  4  one read response returned per set bit.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when all reads have returned.
- err_unexpected_resp  out  1  sticky; cleared only by reset.

Behaviour:
- Reset: state=IDLE; read_valid=0; all read_* bits=0; done=0; busy=0; err=0; outstanding=0; round=0; pending=0; roundOpen=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch vs, offset, count, laneRot; round=0.
  - count==0 -> DONE. Otherwise load pending for round 0 -> ISSUE.
  - Command accepted in cycle N gives the earliest read_valid in cycle N+1.
- Element e = 4r+s is handled by slot s in round r. A slot is pending iff 4r+s < count.
- Per-slot fields:
  - vs = latched vs.
  - offset = (cmd_offset + r) mod 512.
  - readLane = (s + r + laneRot) mod 4.
  - dataOffset = r[1:0].
- ISSUE round opening:
  - If !roundOpen and outstanding <= MAX_OUTSTANDING-4, set roundOpen.
  - read_valid = pending & {4{roundOpen}}, combinationally from registers. It does not depend on read_ready.
- Handshake:
  - A slot's valid and bits stay stable until accepted (valid & ready).
  - Accepted slots clear their pending bit. Denied slots retry every cycle with no limit.
- Round end: when pending becomes 0, clear roundOpen and increment round.
  - If 4*round >= count -> DRAIN. Otherwise load the next pending mask and stay in ISSUE.
  - A round completed in cycle N gives the next round's valid no earlier than N+2.
- Outstanding counter:
  - next = outstanding + popcount(accepts) - popcount(resp_valid).
  - Accepts and responses in the same cycle are both applied.
  - The counter never exceeds MAX_OUTSTANDING; the round-open credit check guarantees this.
- Unexpected responses: if popcount(resp_valid) > outstanding + popcount(accepts), set err sticky and saturate the counter at 0. This also covers responses arriving in IDLE, e.g. stale responses after reset.
- DRAIN: when outstanding==0 after update -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE. cmd_ready=0 during DONE.
- Reset mid-operation: all state returns to reset values the next cycle. In-flight reads are abandoned.

Test Plan:
- count=4, laneRot=0, read_ready=1111, resp_valid one cycle later -> cycle 1 read_valid=1111 with readLanes 0,1,2,3 and offset=base. Cycle 2 resp_valid=1111. done pulses in cycle 4.
- count=6, laneRot=1, offset=0x1FF, ready=1111 -> round 0: lanes 1,2,3,0, offset 0x1FF. Round 1: valid=0011, lanes 2,3, offset 0x000, dataOffset=1. done only after 6 responses.
- Conflict retry: count=4, read_ready=0101 for 3 cycles, then 1111 -> slots 1 and 3 hold valid with unchanged bits. Round 1 never opens early. outstanding peaks at 4.
- Credit: MAX_OUTSTANDING=8, count=16, no responses -> exactly 8 reads accepted, then read_valid=0. One cycle with resp_valid=1111 -> round 2 opens.
- count=0 -> done pulses in the cycle after cmd acceptance with no read_valid. resp_valid=0001 in IDLE -> err=1, held until reset.
- Reset asserted mid-ISSUE with 3 outstanding -> next cycle IDLE, cmd_ready=1, read_valid=0, outstanding=0. A later stale response sets err.
